// File: rtl/spi_bridge_pkg.sv
// Shared opcodes, FSM state types and reply helper for the SPI host bridge.
package spi_bridge_pkg;

  localparam int LOAD_BYTES_DEF = 8;

  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_CFG    = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  typedef enum logic [1:0] {F_IDLE, F_CMD, F_PAYLOAD, F_DRAIN} frame_state_t;
  typedef enum logic       {B_IDLE, B_RUN} burst_state_t;

  function automatic logic op_known(input logic [7:0] op);
    return op inside {OP_LOAD, OP_CFG, OP_READ, OP_STATUS};
  endfunction

  // Byte shifted out on MISO for each payload byte of a frame with opcode op.
  function automatic logic [7:0] miso_reply(input logic [7:0] op,
                                            input logic [7:0] result,
                                            input logic [2:0] status);
    logic [7:0] r;
    r = 8'h00;
    if (op == OP_READ)   r = result;
    if (op == OP_STATUS) r = {status, 5'b0};
    return r;
  endfunction

endpackage

// File: rtl/spi_host_bridge_if.sv
// SPI pins plus TPU core data/control pins seen by the host bridge.
interface spi_host_bridge_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tpu_data;
  logic       tpu_load_en;
  logic       tpu_transpose;
  logic       tpu_activation;
  logic [7:0] tpu_result;
  logic [2:0] tpu_status;
  logic       busy;
  logic       frame_err;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tpu_result, tpu_status,
    input  spi_miso, spi_miso_oe, tpu_data, tpu_load_en, tpu_transpose,
           tpu_activation, busy, frame_err
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tpu_result, tpu_status,
    output spi_miso, spi_miso_oe, tpu_data, tpu_load_en, tpu_transpose,
           tpu_activation, busy, frame_err
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter: synchronizers, edge detect, bit counter, MOSI/MISO shift.
// Latency: SYNC_STAGES + 1 clk from pin edge to event; byte_valid on the 8th detected rise.
// No backpressure: SCLK must stay at or below clk/4, tx_byte is taken at every byte start.
module spi_byte_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       spi_miso,
  output logic       cs_active,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_q, cs_q;
  logic       sclk_rise, sclk_fall, byte_start;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi_sclk);
      cs_sync   <= (cs_sync << 1)   | SYNC_STAGES'(spi_cs_n);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_q & ~cs_s;
  assign sclk_fall  = ~sclk_s & sclk_q & ~cs_s;
  assign cs_fall    = ~cs_s & cs_q;
  assign cs_rise    = cs_s & ~cs_q;
  assign cs_active  = ~cs_s;
  assign byte_valid = sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte    = {rx_shift, mosi_s};
  assign byte_start = byte_valid | cs_fall;
  assign spi_miso   = tx_shift[7];

  // No shift on the fall after the 8th rise: the next byte was just loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
    end else if (cs_s) begin
      bit_cnt  <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (byte_start)
        tx_shift <= tx_byte;
      else if (sclk_fall && bit_cnt != 3'd0)
        tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_host_bridge.sv
// SPI host front end for the TPU core: frame decode, load buffer, config bits, load burst.
// Latency: commit to tpu_load_en one clk; config and frame_err one clk after the triggering event.
// No backpressure: bursts are shorter than one SPI byte, so a commit never meets a running burst.
module spi_host_bridge
  import spi_bridge_pkg::*;
#(
  parameter int LOAD_BYTES  = LOAD_BYTES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  spi_host_bridge_if.slave bus
);

  localparam int CW = (LOAD_BYTES > 1) ? $clog2(LOAD_BYTES) : 1;
  localparam int PW = $clog2(LOAD_BYTES + 1);

  logic       cs_active, cs_fall, cs_rise, byte_valid;
  logic [7:0] rx_byte, tx_byte;

  spi_byte_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (bus.spi_sclk),
    .spi_cs_n   (bus.spi_cs_n),
    .spi_mosi   (bus.spi_mosi),
    .tx_byte    (tx_byte),
    .spi_miso   (bus.spi_miso),
    .cs_active  (cs_active),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  frame_state_t  f_state, f_next;
  burst_state_t  b_state, b_next;
  logic [7:0]    opcode;
  logic [PW-1:0] pay_cnt;
  logic [7:0]    load_buf [LOAD_BYTES];
  logic [1:0]    cfg;
  logic          frame_err;
  logic          err_next, commit, buf_we, cfg_we, op_we, cnt_inc, load_open;
  logic [CW-1:0] b_cnt;
  logic          load_en;
  logic [7:0]    data;

  assign load_open = pay_cnt < PW'(LOAD_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_state <= F_IDLE;
    else        f_state <= f_next;
  end

  always_comb begin
    f_next   = f_state;
    err_next = 1'b0;
    commit   = 1'b0;
    buf_we   = 1'b0;
    cfg_we   = 1'b0;
    op_we    = 1'b0;
    cnt_inc  = 1'b0;
    tx_byte  = 8'h00;
    if (cs_rise) begin
      f_next = F_IDLE;
      // A LOAD cut short is the only payload truncation that counts as malformed.
      if (f_state == F_PAYLOAD && opcode == OP_LOAD && load_open)
        err_next = 1'b1;
    end else begin
      case (f_state)
        F_IDLE: if (cs_fall) f_next = F_CMD;
        F_CMD: if (byte_valid) begin
          op_we = 1'b1;
          if (op_known(rx_byte)) begin
            f_next  = F_PAYLOAD;
            tx_byte = miso_reply(rx_byte, bus.tpu_result, bus.tpu_status);
          end else begin
            f_next   = F_DRAIN;
            err_next = 1'b1;
          end
        end
        F_PAYLOAD: if (byte_valid) begin
          tx_byte = miso_reply(opcode, bus.tpu_result, bus.tpu_status);
          cnt_inc = load_open;
          if (opcode == OP_LOAD && load_open) begin
            buf_we = 1'b1;
            commit = (pay_cnt == PW'(LOAD_BYTES - 1));
          end
          if (opcode == OP_CFG && pay_cnt == '0)
            cfg_we = 1'b1;
        end
        F_DRAIN: f_next = F_DRAIN;
        default: f_next = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode    <= 8'h00;
      pay_cnt   <= '0;
      cfg       <= 2'b00;
      frame_err <= 1'b0;
      for (int i = 0; i < LOAD_BYTES; i++) load_buf[i] <= 8'h00;
    end else begin
      frame_err <= err_next;
      if (op_we) begin
        opcode  <= rx_byte;
        pay_cnt <= '0;
      end else if (cnt_inc) begin
        pay_cnt <= pay_cnt + PW'(1);
      end
      if (buf_we) load_buf[pay_cnt[CW-1:0]] <= rx_byte;
      if (cfg_we) cfg <= rx_byte[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state <= B_IDLE;
      b_cnt   <= '0;
    end else begin
      b_state <= b_next;
      b_cnt   <= (b_state == B_RUN && b_next == B_RUN) ? b_cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    b_next  = b_state;
    load_en = 1'b0;
    data    = 8'h00;
    case (b_state)
      B_IDLE: if (commit) b_next = B_RUN;
      B_RUN: begin
        load_en = 1'b1;
        data    = load_buf[b_cnt];
        if (b_cnt == CW'(LOAD_BYTES - 1)) b_next = B_IDLE;
      end
      default: b_next = B_IDLE;
    endcase
  end

  assign bus.tpu_data       = data;
  assign bus.tpu_load_en    = load_en;
  assign bus.busy           = load_en;
  assign bus.tpu_transpose  = cfg[0];
  assign bus.tpu_activation = cfg[1];
  assign bus.frame_err      = frame_err;
  assign bus.spi_miso_oe    = cs_active;

endmodule

// File: tb/tb_spi_host_bridge.sv
// Directed plus randomized frames against a byte-level model of the SPI host bridge.
module tb_spi_host_bridge;
  import spi_bridge_pkg::*;

  localparam int LB   = 8;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_host_bridge_if bus();

  spi_host_bridge #(.LOAD_BYTES(LB), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_err = 0;
  int         err_cycles = 0;
  int         run_len = 0;
  int         len_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_load[$];
  logic [1:0] cfg_m;
  logic       oe_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records every burst the core would see and the length of each.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (bus.frame_err) err_cycles++;
      check("busy_tracks_load_en", 32'(bus.busy), 32'(bus.tpu_load_en));
      if (bus.tpu_load_en) begin
        obs_q.push_back(bus.tpu_data);
        run_len++;
      end else begin
        check("idle_data_zero", 32'(bus.tpu_data), 32'h0);
        if (run_len != 0) begin
          len_q.push_back(run_len);
          run_len = 0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      #(HALF);
      rx[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      #(HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int tail_bits);
    logic [7:0] r;
    rx_q.delete();
    bus.spi_cs_n = 1'b0;
    #(HALF);
    oe_seen = bus.spi_miso_oe;
    foreach (tx_q[i]) begin
      spi_byte(tx_q[i], 8, r);
      rx_q.push_back(r);
    end
    if (tail_bits > 0) spi_byte(8'hFF, tail_bits, r);
    #(HALF);
    bus.spi_cs_n = 1'b1;
    #(6 * HALF);
  endtask

  task automatic check_bursts(input bit expect_one, input string tag);
    if (expect_one) begin
      check({tag, "_burst_count"}, len_q.size(), 1);
      if (len_q.size() > 0) check({tag, "_burst_len"}, len_q[0], LB);
      check({tag, "_burst_bytes"}, obs_q.size(), LB);
      for (int i = 0; i < LB && i < obs_q.size(); i++)
        check({tag, "_burst_data"}, obs_q[i], exp_load[i]);
    end else begin
      check({tag, "_no_burst"}, len_q.size(), 0);
      check({tag, "_no_load_bytes"}, obs_q.size(), 0);
    end
    obs_q.delete();
    len_q.delete();
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_transpose"}, bus.tpu_transpose, cfg_m[0]);
    check({tag, "_activation"}, bus.tpu_activation, cfg_m[1]);
  endtask

  initial begin
    int         op, n;
    logic [7:0] b;

    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tpu_result = 8'h00;
    bus.tpu_status = 3'b000;
    cfg_m = 2'b00;
    #23;
    check("rst_miso", bus.spi_miso, 0);
    check("rst_miso_oe", bus.spi_miso_oe, 0);
    check("rst_tpu_data", bus.tpu_data, 0);
    check("rst_load_en", bus.tpu_load_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check_cfg("rst");
    #20 rst_n = 1'b1;
    #100;

    // LOAD 0x11..0x88
    tx_q.delete(); exp_load.delete();
    tx_q.push_back(OP_LOAD);
    for (int i = 1; i <= LB; i++) begin
      tx_q.push_back(8'(i * 17));
      exp_load.push_back(8'(i * 17));
    end
    err_cycles = 0;
    spi_frame(0);
    check_bursts(1'b1, "load");
    check("load_err", err_cycles, 0);
    check("oe_in_frame", oe_seen, 1);
    check("oe_after_frame", bus.spi_miso_oe, 0);

    // CFG set then clear
    tx_q = '{OP_CFG, 8'h03};
    spi_frame(0);
    cfg_m = 2'b11;
    check_cfg("cfg_03");
    tx_q = '{OP_CFG, 8'hFC};
    spi_frame(0);
    cfg_m = 2'b00;
    check_cfg("cfg_fc");

    // READ
    bus.tpu_result = 8'hA5;
    tx_q = '{OP_READ, 8'h00, 8'h00};
    spi_frame(0);
    check("read_b0", rx_q[0], 8'h00);
    check("read_b1", rx_q[1], 8'hA5);
    check("read_b2", rx_q[2], 8'hA5);

    // STATUS
    bus.tpu_status = 3'b110;
    tx_q = '{OP_STATUS, 8'h00};
    spi_frame(0);
    check("status_b0", rx_q[0], 8'h00);
    check("status_b1", rx_q[1], 8'hC0);

    // Short LOAD
    tx_q = '{OP_LOAD, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    err_cycles = 0;
    spi_frame(0);
    check("short_load_err_pulse", err_cycles, 1);
    check_bursts(1'b0, "short_load");

    // Unknown opcode
    tx_q = '{8'h7F, 8'hAA, 8'h55};
    err_cycles = 0;
    spi_frame(0);
    check("unknown_err_pulse", err_cycles, 1);
    check("unknown_b0", rx_q[0], 8'h00);
    check("unknown_b1", rx_q[1], 8'h00);
    check("unknown_b2", rx_q[2], 8'h00);
    check_bursts(1'b0, "unknown");

    // LOAD with extra trailing bytes
    tx_q.delete(); exp_load.delete();
    tx_q.push_back(OP_LOAD);
    for (int i = 0; i < LB + 2; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      if (i < LB) exp_load.push_back(b);
    end
    err_cycles = 0;
    spi_frame(0);
    check("extra_load_err", err_cycles, 0);
    check_bursts(1'b1, "extra_load");

    // CFG cut off mid-byte leaves config alone; following frame stays aligned
    tx_q = '{OP_CFG, 8'h01};
    spi_frame(0);
    cfg_m = 2'b01;
    check_cfg("cfg_01");
    tx_q = '{OP_CFG};
    err_cycles = 0;
    spi_frame(4);
    check("partial_cfg_err", err_cycles, 0);
    check_cfg("partial_cfg");
    bus.tpu_result = 8'h3C;
    tx_q = '{OP_READ, 8'h00};
    spi_frame(0);
    check("realign_b0", rx_q[0], 8'h00);
    check("realign_b1", rx_q[1], 8'h3C);

    // Randomized frames against the model
    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(1, 4);
      tx_q.delete(); exp_rx.delete();
      tx_q.push_back(8'(op));
      exp_rx.push_back(8'h00);
      if (op == 1) begin
        exp_load.delete();
        n = $urandom_range(LB, LB + 2);
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom);
          tx_q.push_back(b);
          exp_rx.push_back(8'h00);
          if (j < LB) exp_load.push_back(b);
        end
      end else if (op == 2) begin
        b = 8'($urandom);
        tx_q.push_back(b);
        exp_rx.push_back(8'h00);
        cfg_m = b[1:0];
      end else begin
        bus.tpu_result = 8'($urandom);
        bus.tpu_status = 3'($urandom);
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          tx_q.push_back(8'($urandom));
          exp_rx.push_back(op == 3 ? bus.tpu_result : {bus.tpu_status, 5'b0});
        end
      end
      err_cycles = 0;
      spi_frame(0);
      for (int j = 0; j < exp_rx.size(); j++)
        check("rand_miso", rx_q[j], exp_rx[j]);
      check_bursts(op == 1, "rand");
      check("rand_err", err_cycles, 0);
      check_cfg("rand");
    end

    // Reset asserted on burst cycle 3
    tx_q.delete(); exp_load.delete();
    tx_q.push_back(OP_LOAD);
    for (int i = 0; i < LB; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      exp_load.push_back(b);
    end
    fork
      spi_frame(0);
      begin
        for (int i = 0; i < 4000 && !bus.tpu_load_en; i++) @(negedge clk);
        check("rst_burst_started", bus.tpu_load_en, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_load_en", bus.tpu_load_en, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_data", bus.tpu_data, 0);
        check("midrst_frame_err", bus.frame_err, 0);
        check("midrst_miso_oe", bus.spi_miso_oe, 0);
        cfg_m = 2'b00;
        check_cfg("midrst");
      end
    join
    obs_q.delete();
    len_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    #2;
    check_bursts(1'b0, "no_resume");

    // Fresh LOAD after reset
    tx_q.delete(); exp_load.delete();
    tx_q.push_back(OP_LOAD);
    for (int i = 0; i < LB; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      exp_load.push_back(b);
    end
    err_cycles = 0;
    spi_frame(0);
    check_bursts(1'b1, "post_rst");
    check("post_rst_err", err_cycles, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_host_bridge.md
# spi_host_bridge

Host-facing front end for the 2x2 TPU core. Receives SPI mode-0 frames from an external microcontroller, buffers an 8-byte weight/input load, and replays it into the core as one 8-cycle `load_en` burst. Holds the core's `transpose`/`activation` configuration bits and returns result and status bytes over MISO. Sits directly upstream of the TPU core's data/control pins.

## Interface
Parameters:
- `LOAD_BYTES`, 8, bytes per LOAD frame and length of the `load_en` burst
- `SYNC_STAGES`, 2, synchronizer depth on `spi_sclk`, `spi_cs_n`, `spi_mosi`

Ports:
- `clk`  in  1  system clock; all logic in this domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `spi_sclk`  in  1  SPI clock, asynchronous, must be ≤ `clk`/4
- `spi_cs_n`  in  1  chip select, active-low, asynchronous
- `spi_mosi`  in  1  host-to-device data, MSB first
- `spi_miso`  out  1  device-to-host data, MSB first
- `spi_miso_oe`  out  1  MISO drive enable, high while CS is (synchronized) low
- `tpu_data`  out  8  byte presented to the core's data input
- `tpu_load_en`  out  1  core load strobe, high for exactly `LOAD_BYTES` consecutive cycles per burst
- `tpu_transpose`  out  1  config bit, held
- `tpu_activation`  out  1  config bit, held
- `tpu_result`  in  8  core result byte
- `tpu_status`  in  3  {done, state[1:0]} from the core
- `busy`  out  1  high while a burst is in progress
- `frame_err`  out  1  one-cycle pulse on malformed frame

## Operation
- Frame = `spi_cs_n` low period. First byte is the command; later bytes are payload.
- Opcodes:
  - 0x01 LOAD: next `LOAD_BYTES` MOSI bytes are stored in buffer slots 0..7.
  - 0x02 CFG: next byte sets {`tpu_activation`,`tpu_transpose`} = bits[1:0]. Bits[7:2] are ignored.
  - 0x03 READ: every payload byte shifts out `tpu_result` as sampled at that byte's start.
  - 0x04 STATUS: every payload byte shifts out {`tpu_status`, 5'b0}.
- Frame FSM: IDLE → CMD on CS fall → PAYLOAD on a valid opcode, or DRAIN on an unknown opcode (`frame_err` pulse) → IDLE on CS rise from any state.
- LOAD completion: after the 8th payload byte, the buffer is committed and a burst starts. Extra bytes are ignored and do not raise an error.
- CS rise during LOAD with fewer than 8 payload bytes: buffer is discarded, no burst, `frame_err` pulse.
- CS rise during CFG before a full payload byte: config is unchanged, no error.
- Partial bits at CS rise are always discarded, and the bit counter resets.
- Burst FSM: B_IDLE → B_RUN on commit. In B_RUN, a 3-bit counter drives slot k on `tpu_data` with `tpu_load_en`=1 for cycles k=0..7, then returns to B_IDLE.
- Outside a burst, `tpu_data`=0 and `tpu_load_en`=0.
- The next commit cannot arrive before a burst ends: a byte takes ≥32 `clk` cycles at the SCLK limit.
- MISO during the command byte shifts 0x00.

## Timing
- Reset values:
  - `spi_miso`, `spi_miso_oe`, `tpu_data`, `tpu_load_en`, `busy`, `frame_err` = 0
  - config bits = 0
  - both FSMs idle, buffer cleared
- Input latency: `SYNC_STAGES` cycles plus 1 cycle of edge detection.
- MOSI is sampled on the detected SCLK rise. MISO updates on the detected SCLK fall; the first bit is valid on the cycle after the byte-start event.
- Commit → `tpu_load_en` high on the next `clk` cycle. `busy` tracks `tpu_load_en` exactly.
- CFG takes effect 1 cycle after the 8th payload bit is sampled.
- `frame_err` fires 1 cycle after the offending event (opcode decode or CS rise).
- Async reset mid-burst: `tpu_load_en` drops immediately, and the burst is not resumed.

## Structure
- Package `spi_bridge_pkg`: opcode constants, frame-FSM and burst-FSM state enums, `LOAD_BYTES` default.
- Sub-module `spi_byte_shifter` holds the synchronizers, edge detect, bit counter, and MOSI/MISO shift registers. It outputs `byte_valid`/`rx_byte` and accepts `tx_byte` at each byte start.
- Top holds the frame FSM, buffer, config register and burst FSM.

## Test plan
- LOAD 0x01 + bytes 0x11..0x88 → 8 consecutive cycles `tpu_load_en`=1 with `tpu_data` 0x11,0x22,…,0x88; `busy` identical; then 0.
- CFG 0x02,0x03 → `tpu_transpose`=1, `tpu_activation`=1. A later CFG 0x02,0xFC → both 0.
- READ 0x03 + 2 dummy bytes with `tpu_result`=0xA5 → MISO returns 0x00,0xA5,0xA5.
- STATUS with `tpu_status`=3'b110 → MISO returns 0xC0.
- LOAD with 5 payload bytes then CS high → `frame_err` one pulse, no `tpu_load_en`. Unknown opcode 0x7F → `frame_err` pulse, MISO 0x00 for the rest of the frame.
- Assert `rst_n` low on burst cycle 3 → all outputs 0 immediately. After release, a fresh LOAD bursts normally.
